// File: rtl/ext_out_uart_tx_if.sv
// rtl/ext_out_uart_tx_if.sv - ext_out capture input and UART/status outputs of ext_out_uart_tx
interface ext_out_uart_tx_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    ext_out;
   logic          tx;
   logic          busy;
   logic          ovf;
   logic [CW-1:0] fifo_count;

   modport master (output ext_out, input tx, busy, ovf, fifo_count);
   modport slave  (input ext_out, output tx, busy, ovf, fifo_count);
endinterface

// File: rtl/ext_out_uart_tx.sv
// rtl/ext_out_uart_tx.sv - change-detecting capture FIFO feeding an 8N1 UART transmitter
module ext_out_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input logic clk,
   input logic rst,
   ext_out_uart_tx_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   logic [7:0]    last_val;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_q;
   logic          ovf_q;

   logic push_req, pop, push_ok;

   // ext_out has no strobe: any difference from the last seen value is a new byte
   assign push_req = (bus.ext_out != last_val);
   // the transmitter only takes a byte while idle, so a byte pushed into an empty FIFO waits one edge
   assign pop      = (state_q == IDLE) && (count_q != '0);
   // a full FIFO can still accept when the head leaves on the same edge
   assign push_ok  = push_req && ((count_q < DEPTH_C) || pop);

   assign bus.tx         = tx_q;
   assign bus.ovf        = ovf_q;
   assign bus.fifo_count = count_q;
   assign bus.busy       = (state_q != IDLE) || (count_q != '0);

   // capture register, FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_val <= 8'h00;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_req) last_val <= bus.ext_out;
         if (push_req && !push_ok) ovf_q <= 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage; contents are meaningless until written, so no reset
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= bus.ext_out;
   end

   // transmitter state register; tx is registered so the line never glitches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // next-state logic; tx_d is the line level for the period that begins at the coming edge
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (pop) begin
               state_d = START;
               baud_d  = '0;
               bit_d   = '0;
               shift_d = mem[rd_ptr];
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (baud_q == BAUD_LAST) begin
               state_d = DATA;
               baud_d  = '0;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_q == BAUD_LAST) begin
               state_d = IDLE;
               baud_d  = '0;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end
endmodule

// File: tb/tb_ext_out_uart_tx.sv
// tb/tb_ext_out_uart_tx.sv - scoreboard bench for ext_out_uart_tx with a queue-level reference model
module tb_ext_out_uart_tx;
   localparam int C = 4;
   localparam int D = 4;
   localparam int FRAME = 10 * C;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   ext_out_uart_tx_if #(.FIFO_DEPTH(D)) bus ();

   ext_out_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // cycle counter used to timestamp start bits
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model: pending bytes, transmitter occupancy in cycles, expected frame order
   byte unsigned m_fifo[$];
   byte unsigned exp_q[$];
   logic [7:0]   m_last;
   int           m_rem;
   bit           m_ovf;
   bit           m_pop;
   int           m_size0;

   // model update at each edge from the sampled ext_out value
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_fifo.delete();
         exp_q.delete();
         m_last = 8'h00;
         m_rem  = 0;
         m_ovf  = 1'b0;
      end else begin
         m_size0 = m_fifo.size();
         m_pop   = (m_rem == 0) && (m_size0 != 0);
         if (m_pop) begin
            exp_q.push_back(m_fifo.pop_front());
            m_rem = FRAME;
         end else if (m_rem > 0) begin
            m_rem--;
         end
         if (bus.ext_out != m_last) begin
            m_last = bus.ext_out;
            if (m_size0 < D || m_pop) m_fifo.push_back(bus.ext_out);
            else m_ovf = 1'b1;
         end
      end
   end

   // per-cycle status comparison against the model
   always @(negedge clk) begin
      check("fifo_count", bus.fifo_count, m_fifo.size());
      check("ovf", bus.ovf, m_ovf);
      check("busy", bus.busy, (m_rem != 0) || (m_fifo.size() != 0));
      if (m_rem == 0) check("tx_idle", bus.tx, 1);
   end

   // frame monitor: decodes tx at every sample and compares against the expected-frame queue
   bit         mon_act = 1'b0;
   bit         mon_ok;
   int         mon_t;
   int         mon_b;
   int         mon_p;
   logic [7:0] mon_byte;
   int         frames_seen = 0;
   int         starts[$];

   always @(negedge clk) begin
      if (!rst) begin
         mon_act = 1'b0;
      end else begin
         if (!mon_act && bus.tx === 1'b0) begin
            mon_act  = 1'b1;
            mon_t    = 0;
            mon_ok   = 1'b1;
            mon_byte = 8'h00;
            starts.push_back(cyc);
         end
         if (mon_act) begin
            mon_t++;
            mon_b = (mon_t - 1) / C;
            mon_p = (mon_t - 1) % C;
            if (mon_b == 0) begin
               if (bus.tx !== 1'b0) mon_ok = 1'b0;
            end else if (mon_b <= 8) begin
               if (mon_p == 0) mon_byte[mon_b-1] = bus.tx;
               else if (bus.tx !== mon_byte[mon_b-1]) mon_ok = 1'b0;
            end else begin
               if (bus.tx !== 1'b1) mon_ok = 1'b0;
            end
            if (mon_t == FRAME) begin
               check("frame_timing", mon_ok, 1);
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_frame: got frame 0x%02h expected none", mon_byte);
               end else begin
                  check("frame_data", mon_byte, exp_q.pop_front());
               end
               frames_seen++;
               mon_act = 1'b0;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input int budget);
      int i;
      i = 0;
      while ((m_rem != 0 || m_fifo.size() != 0 || mon_act) && i < budget) begin
         @(negedge clk);
         i++;
      end
      check("drain_in_time", (i < budget), 1);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0;
      logic [7:0] v;

      // reset held with a nonzero value on ext_out
      bus.ext_out = 8'h5A;
      rst = 1'b0;
      tick(3);
      check("rst_tx", bus.tx, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_ovf", bus.ovf, 0);
      check("rst_count", bus.fifo_count, 0);
      rst = 1'b1;
      tick(2);
      wait_idle(300);
      check("frames_after_reset", frames_seen, 1);

      // single change 0x00 -> 0xA5 with exact latency
      rst = 1'b0;
      bus.ext_out = 8'h00;
      tick(2);
      rst = 1'b1;
      tick(3);
      check("zero_not_sent", frames_seen, 1);
      f0 = frames_seen;
      bus.ext_out = 8'hA5;
      @(negedge clk);
      check("lat_count", bus.fifo_count, 1);
      check("lat_tx_high", bus.tx, 1);
      @(negedge clk);
      check("lat_tx_start", bus.tx, 0);
      check("lat_count_popped", bus.fifo_count, 0);
      wait_idle(300);
      check("a5_frames", frames_seen, f0 + 1);
      tick(200);
      check("hold_no_resend", frames_seen, f0 + 1);
      check("hold_count", bus.fifo_count, 0);

      // burst 0x01..0x06 one per cycle: overflow on the sixth
      starts.delete();
      f0 = frames_seen;
      for (int i = 1; i <= 6; i++) begin
         bus.ext_out = 8'(i);
         @(negedge clk);
      end
      check("burst_count_full", bus.fifo_count, 4);
      check("burst_ovf", bus.ovf, 1);
      wait_idle(1000);
      check("burst_frames", frames_seen, f0 + 5);
      check("burst_starts", starts.size(), 5);
      for (int i = 1; i < starts.size(); i++)
         check("frame_spacing", starts[i] - starts[i-1], FRAME + 1);

      // reset in the middle of DATA with two bytes queued
      bus.ext_out = 8'h33;
      @(negedge clk);
      bus.ext_out = 8'h44;
      @(negedge clk);
      bus.ext_out = 8'h55;
      tick(8);
      check("mid_count_before", bus.fifo_count, 2);
      #1 rst = 1'b0;
      #1;
      check("mid_rst_tx", bus.tx, 1);
      check("mid_rst_count", bus.fifo_count, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_ovf", bus.ovf, 0);
      tick(2);
      rst = 1'b1;
      f0 = frames_seen;
      tick(2);
      wait_idle(300);
      check("held_after_reset", frames_seen, f0 + 1);

      // return to zero is a change
      f0 = frames_seen;
      bus.ext_out = 8'h12;
      tick(3);
      bus.ext_out = 8'h00;
      tick(2);
      wait_idle(300);
      check("rtz_frames", frames_seen, f0 + 2);

      // randomized values and hold times, including repeats and bursts
      v = 8'h00;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) != 0) v = 8'($urandom_range(0, 255));
         bus.ext_out = v;
         tick($urandom_range(0, 50));
      end
      tick(2);
      wait_idle(5000);
      check("exp_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
